// File: rtl/tff_bank_pkg.sv
// Shared encodings for the toggle flip-flop bank sequencer:
// command opcodes and controller states.
package tff_bank_pkg;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_UP    = 2'b10;
    localparam logic [1:0] OP_DOWN  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/tff_bank_seq_if.sv
// Command handshake bundle for tff_bank_seq: the requester drives
// valid/op/data, the sequencer answers with ready.
interface tff_bank_seq_if #(
    parameter int WIDTH = 4
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/tff_bank_cell.sv
// One T flip-flop: inverts its state on a clock edge when t is high.
module tff_bank_cell (
    input  logic clk,
    input  logic rstn,
    input  logic t,
    output logic q
);
    logic q_d;
    logic q_q;

    // Next state: toggle or hold.
    always_comb begin
        if (t) begin
            q_d = ~q_q;
        end else begin
            q_d = q_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/tff_bank_seq.sv
// Command sequencer for a bank of T flip-flops: the count only ever
// changes through a per-bit toggle-enable vector computed here.
module tff_bank_seq
    import tff_bank_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    tff_bank_seq_if.slave    cmd,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              done_q, done_d;
    logic              wrap_q, wrap_d;
    logic [WIDTH-1:0]  count_s;
    logic [WIDTH-1:0]  tvec_s;
    logic [WIDTH-1:0]  tvec_run_s;
    logic [STEP_W-1:0] step_s;
    logic              run_carry_s;
    logic              wrap_hit_s;

    // Step count is the low STEP_W bits of cmd_data, zero-extended if wider.
    if (STEP_W <= WIDTH) begin : g_step_slice
        assign step_s = cmd.cmd_data[STEP_W-1:0];
    end else begin : g_step_ext
        assign step_s = {{(STEP_W-WIDTH){1'b0}}, cmd.cmd_data};
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        tff_bank_cell u_cell (
            .clk  (clk),
            .rstn (rstn),
            .t    (tvec_s[i]),
            .q    (count_s[i])
        );
    end

    // Ripple toggle enables for counting: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        tvec_run_s  = '0;
        run_carry_s = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tvec_run_s[i] = run_carry_s;
            if (op_q == OP_DOWN) begin
                run_carry_s = run_carry_s & ~count_s[i];
            end else begin
                run_carry_s = run_carry_s & count_s[i];
            end
        end
        wrap_hit_s = run_carry_s;
    end

    // Next-state, toggle vector and flag logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        steps_d = steps_q;
        done_d  = 1'b0;
        wrap_d  = wrap_q;
        tvec_s  = '0;
        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    op_d   = cmd.cmd_op;
                    data_d = cmd.cmd_data;
                    wrap_d = 1'b0;
                    if ((cmd.cmd_op == OP_CLEAR) || (cmd.cmd_op == OP_LOAD)) begin
                        state_d = APPLY;
                    end else if (step_s == '0) begin
                        done_d = 1'b1;
                    end else begin
                        steps_d = step_s;
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            APPLY: begin
                if (op_q == OP_LOAD) begin
                    tvec_s = count_s ^ data_q;
                end else begin
                    tvec_s = count_s;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            RUN: begin
                if (pause) begin
                    tvec_s = '0;
                end else begin
                    tvec_s  = tvec_run_s;
                    steps_d = steps_q - STEP_ONE;
                    if (wrap_hit_s) begin
                        wrap_d = 1'b1;
                    end else begin
                        wrap_d = wrap_q;
                    end
                    if (steps_q == STEP_ONE) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            op_q    <= OP_CLEAR;
            data_q  <= '0;
            steps_q <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            steps_q <= steps_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign cmd.cmd_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign count         = count_s;
    assign done          = done_q;
    assign wrap          = wrap_q;
endmodule

// File: tb/tb_tff_bank_seq.sv
// Self-checking bench for tff_bank_seq (WIDTH=4, STEP_W=4): a cycle-by-cycle
// vector table through a scoreboard queue, then randomised load/up runs.
module tb_tff_bank_seq;
    import tff_bank_pkg::*;

    typedef struct {
        logic       rstn;
        logic       valid;
        logic [1:0] op;
        logic [3:0] data;
        logic       pause;
        logic [3:0] e_count;
        logic       e_done;
        logic       e_wrap;
        logic       e_ready;
    } vec_t;

    typedef struct {
        logic [3:0] count;
        logic       done;
        logic       wrap;
        logic       ready;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic       pause;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       wrap;

    int total;
    int bad;
    exp_t sb[$];
    vec_t tv[64];
    int   nv;

    tff_bank_seq_if #(.WIDTH(4)) bus ();

    tff_bank_seq #(.WIDTH(4), .STEP_W(4)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .cmd   (bus),
        .pause (pause),
        .count (count),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(logic r, logic v, logic [1:0] op, logic [3:0] d, logic p,
                                 logic [3:0] ec, logic ed, logic ew, logic er);
        vec_t x;
        x.rstn = r; x.valid = v; x.op = op; x.data = d; x.pause = p;
        x.e_count = ec; x.e_done = ed; x.e_wrap = ew; x.e_ready = er;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rstn          = v.rstn;
        bus.cmd_valid = v.valid;
        bus.cmd_op    = v.op;
        bus.cmd_data  = v.data;
        pause         = v.pause;
        sb.push_back('{v.e_count, v.e_done, v.e_wrap, v.e_ready});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("count", 32'(count), 32'(e.count));
        chk("done", 32'(done), 32'(e.done));
        chk("wrap", 32'(wrap), 32'(e.wrap));
        chk("ready", 32'(bus.cmd_ready), 32'(e.ready));
        chk("busy", 32'(busy), 32'(!e.ready));
    endtask

    initial begin
        logic [3:0] cur;
        logic [3:0] st;
        logic [3:0] n;
        logic [4:0] sum;
        bit         seen;
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        pause = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_data  = 4'h5;

        nv = 0;
        // reset with valid held high
        tv[nv++] = mkv(1'b0, 1'b1, OP_LOAD,  4'h5, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        tv[nv++] = mkv(1'b0, 1'b1, OP_LOAD,  4'h5, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        // LOAD 0xA
        tv[nv++] = mkv(1'b1, 1'b1, OP_LOAD,  4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_LOAD,  4'h0, 1'b0, 4'hA, 1'b1, 1'b0, 1'b1);
        tv[nv++] = mkv(1'b1, 1'b0, OP_LOAD,  4'h0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1);
        // LOAD 14, UP 3 wraps
        tv[nv++] = mkv(1'b1, 1'b1, OP_LOAD,  4'hE, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_LOAD,  4'h0, 1'b0, 4'hE, 1'b1, 1'b0, 1'b1);
        tv[nv++] = mkv(1'b1, 1'b1, OP_UP,    4'h3, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b1);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b0, 4'h1, 1'b0, 1'b1, 1'b1);
        // LOAD 2 clears wrap, DOWN 5 wraps
        tv[nv++] = mkv(1'b1, 1'b1, OP_LOAD,  4'h2, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_LOAD,  4'h0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b1);
        tv[nv++] = mkv(1'b1, 1'b1, OP_DOWN,  4'h5, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_DOWN,  4'h0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_DOWN,  4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_DOWN,  4'h0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_DOWN,  4'h0, 1'b0, 4'hE, 1'b0, 1'b1, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_DOWN,  4'h0, 1'b0, 4'hD, 1'b1, 1'b1, 1'b1);
        // CLEAR
        tv[nv++] = mkv(1'b1, 1'b1, OP_CLEAR, 4'h7, 1'b0, 4'hD, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_CLEAR, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        // UP 4 with a 3-cycle pause
        tv[nv++] = mkv(1'b1, 1'b1, OP_UP,    4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b0, 4'h4, 1'b1, 1'b0, 1'b1);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b1);
        // LOAD 5, UP 10 abandoned by reset after 2 steps
        tv[nv++] = mkv(1'b1, 1'b1, OP_LOAD,  4'h5, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_LOAD,  4'h0, 1'b0, 4'h5, 1'b1, 1'b0, 1'b1);
        tv[nv++] = mkv(1'b1, 1'b1, OP_UP,    4'hA, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b0, 1'b0, OP_UP,    4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        // LOAD 9, UP with n=0
        tv[nv++] = mkv(1'b1, 1'b1, OP_LOAD,  4'h9, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_LOAD,  4'h0, 1'b0, 4'h9, 1'b1, 1'b0, 1'b1);
        tv[nv++] = mkv(1'b1, 1'b1, OP_UP,    4'h0, 1'b0, 4'h9, 1'b1, 1'b0, 1'b1);
        tv[nv++] = mkv(1'b1, 1'b0, OP_UP,    4'h0, 1'b0, 4'h9, 1'b0, 1'b0, 1'b1);
        // back-to-back CLEAR then LOAD 3 with valid held
        tv[nv++] = mkv(1'b1, 1'b1, OP_CLEAR, 4'h0, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b1, OP_LOAD,  4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        tv[nv++] = mkv(1'b1, 1'b1, OP_LOAD,  4'h3, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        tv[nv++] = mkv(1'b1, 1'b0, OP_LOAD,  4'h0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < nv; i++) begin
            apply(tv[i]);
        end

        // Randomised LOAD then UP runs, with a bounded wait for done.
        cur = 4'h3;
        for (int k = 0; k < 4; k++) begin
            st = 4'($urandom_range(0, 15));
            n  = 4'($urandom_range(1, 15));
            apply(mkv(1'b1, 1'b1, OP_LOAD, st, 1'b0, cur, 1'b0, 1'b0, 1'b0));
            chk("tvec_apply", 32'(dut.tvec_s), 32'(cur ^ st));
            apply(mkv(1'b1, 1'b0, OP_LOAD, 4'h0, 1'b0, st, 1'b1, 1'b0, 1'b1));
            apply(mkv(1'b1, 1'b1, OP_UP, n, 1'b0, st, 1'b0, 1'b0, 1'b0));
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(posedge clk);
                #1;
                if (done) seen = 1'b1;
            end
            sum = 5'(st) + 5'(n);
            chk("done_seen", 32'(seen), 32'(1'b1));
            chk("run_count", 32'(count), 32'(sum[3:0]));
            chk("run_wrap", 32'(wrap), 32'(sum[4]));
            cur = sum[3:0];
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
